// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308 scan controller: sample/config widths, config bit map, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_pkg;

    localparam int ADC_BITS = 12;
    localparam int CFG_BITS = 6;

    // Config word bit positions, MSB is shifted out first
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT,
        SHIFT,
        STORE,
        GAP
    } state_t;

    // Single-ended, unipolar, no sleep. The ADC's odd/sign bit carries ch[0] and
    // the select pair carries ch[2:1], which is why the bits look shuffled.
    function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
        logic [CFG_BITS-1:0] w;
        w          = '0;
        w[CFG_SD]  = 1'b1;
        w[CFG_OS]  = ch[0];
        w[CFG_S1]  = ch[2];
        w[CFG_S0]  = ch[1];
        w[CFG_UNI] = 1'b1;
        w[CFG_SLP] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/adc_sck_tick.sv
// SCK generator: SCK_HALF-cycle half periods, with rise/fall strobes valid in the cycle before the edge.
// Latency: first rising edge SCK_HALF cycles after en goes high; SCK held low while en is low.
// Backpressure: none; en is the only control.
module adc_sck_tick #(
    parameter int SCK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int            CW     = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SCK_HALF - 1);

    logic [CW-1:0] cnt;
    logic          at_zero;

    assign at_zero = (cnt == '0);
    // Strobes mark the clk edge on which SCK will toggle, so users can sample SDO in step with it
    assign rise    = en & at_zero & ~sck;
    assign fall    = en & at_zero & sck;

    // Half-period down-counter; disabled means reloaded with SCK parked low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= RELOAD;
            sck <= 1'b0;
        end else if (at_zero) begin
            cnt <= RELOAD;
            sck <= ~sck;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// LTC2308 scan master: round-robin single-ended conversions written into a per-channel result bank.
// Latency: CONVST rise to sample_valid is 2 + CONV_CYCLES + 24*SCK_HALF + 1 clk cycles.
// Backpressure: none; results are overwritten in place, en only gates the start of a new frame.
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCK_HALF    = 2,
    parameter int CONV_CYCLES = 80,
    parameter int GAP_CYCLES  = 4,
    parameter int NUM_CH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic                         ADC_CONVST,
    output logic                         ADC_SCK,
    output logic                         ADC_SDI,
    input  logic                         ADC_SDO,
    output logic [NUM_CH*ADC_BITS-1:0]   ch_data,
    output logic                         sample_valid,
    output logic [2:0]                   sample_ch
);

    localparam int CNT_MAX = (CONV_CYCLES > GAP_CYCLES) ? CONV_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Reject parameter sets the frame timing cannot honour
    if (SCK_HALF < 1 || CONV_CYCLES < 1 || GAP_CYCLES < 1 ||
        NUM_CH < 1 || NUM_CH > 8 || CLK_HZ <= 0) begin : g_param_check
        $error("adc_scan_ctrl: illegal parameter set");
    end

    state_t                              state;
    logic [CNT_W-1:0]                    cnt;
    logic [3:0]                          fall_cnt;
    logic [2:0]                          next_ch;
    logic [2:0]                          cur_ch;
    logic [2:0]                          prev_ch;
    logic                                primed;
    logic [ADC_BITS-1:0]                 shreg;
    logic [CFG_BITS-1:0]                 cfg_sh;
    logic [NUM_CH-1:0][ADC_BITS-1:0]     bank;
    logic                                sck_en;
    logic                                sck_rise;
    logic                                sck_fall;

    assign sck_en  = (state == SHIFT);
    // Config shifter MSB drives SDI; it is loaded in WAIT and runs dry to zeros after bit 0
    assign ADC_SDI = cfg_sh[CFG_BITS-1];
    assign ch_data = bank;

    adc_sck_tick #(
        .SCK_HALF (SCK_HALF)
    ) u_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sck_en),
        .sck   (ADC_SCK),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // Frame sequencer: convert, shift config out / result in, store, rest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            fall_cnt     <= '0;
            next_ch      <= '0;
            cur_ch       <= '0;
            prev_ch      <= '0;
            primed       <= 1'b0;
            shreg        <= '0;
            cfg_sh       <= '0;
            bank         <= '0;
            ADC_CONVST   <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state      <= CONV;
                        ADC_CONVST <= 1'b1;
                        cnt        <= CNT_W'(1);
                    end
                end
                CONV: begin
                    if (cnt == '0) begin
                        state      <= WAIT;
                        ADC_CONVST <= 1'b0;
                        cfg_sh     <= cfg_word(next_ch);
                        cnt        <= CNT_W'(CONV_CYCLES - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state    <= SHIFT;
                        cur_ch   <= next_ch;
                        fall_cnt <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SHIFT: begin
                    // SDO is captured on the very edge that raises SCK
                    if (sck_rise) begin
                        shreg <= {shreg[ADC_BITS-2:0], ADC_SDO};
                    end
                    if (sck_fall) begin
                        cfg_sh   <= {cfg_sh[CFG_BITS-2:0], 1'b0};
                        fall_cnt <= fall_cnt + 4'd1;
                        if (fall_cnt == 4'(ADC_BITS - 1)) begin
                            state <= STORE;
                        end
                    end
                end
                STORE: begin
                    // The data just shifted in was converted with the previous frame's config
                    if (primed) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (prev_ch == 3'(i)) begin
                                bank[i] <= shreg;
                            end
                        end
                        sample_valid <= 1'b1;
                        sample_ch    <= prev_ch;
                    end
                    primed  <= 1'b1;
                    prev_ch <= cur_ch;
                    next_ch <= (next_ch == 3'(NUM_CH - 1)) ? 3'd0 : next_ch + 3'd1;
                    cfg_sh  <= '0;
                    state   <= GAP;
                    cnt     <= CNT_W'(GAP_CYCLES - 1);
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Serial-interface master for the on-board LTC2308 8-channel, 12-bit ADC, and the producer side of the wire-module channel registers. It scans single-ended channels 0..NUM_CH-1 continuously and drives CONVST, SCK and SDI. Each returned sample is written into a per-channel result bank, which the memory-mapped wire peripheral reads as its `ch[]` array.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; documentation only, not used in logic.
- `SCK_HALF`, 2: clk cycles per SCK half-period; ≥1; default gives 12.5 MHz SCK.
- `CONV_CYCLES`, 80: clk cycles CONVST is held low before shifting; covers t_CONV of 1.6 µs.
- `GAP_CYCLES`, 4: idle clk cycles between frames; ≥1.
- `NUM_CH`, 8: number of channels scanned; 1..8.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: scan enable; sampled only in IDLE.
- `ADC_CONVST` out 1: conversion start; rising edge starts a conversion.
- `ADC_SCK` out 1: serial clock; idles low.
- `ADC_SDI` out 1: 6-bit config word, MSB first.
- `ADC_SDO` in 1: conversion result, MSB first.
- `ch_data` out NUM_CH*12: result bank; channel n occupies bits [12n+11:12n].
- `sample_valid` out 1: one-cycle strobe when a bank entry is written.
- `sample_ch` out 3: channel written on `sample_valid`.

## Operation
- Reset values: `ADC_CONVST`=0, `ADC_SCK`=0, `ADC_SDI`=0, `ch_data`=0, `sample_valid`=0, `sample_ch`=0. Internal state after reset: state=IDLE, next_ch=0, primed=0.
- Config word for channel c, single-ended and unipolar: {S/D=1, O/S=c[0], S1=c[2], S0=c[1], UNI=1, SLP=0}.
- FSM states and transitions:
  - IDLE: if `en`=1, go to CONV.
  - CONV: `ADC_CONVST`=1 for 2 clk cycles, then go to WAIT.
  - WAIT: `ADC_CONVST`=0 for CONV_CYCLES cycles; `ADC_SDI` presents config bit 5 of next_ch; then go to SHIFT.
  - SHIFT: 12 SCK periods.
  - STORE: 1 cycle.
  - GAP: GAP_CYCLES cycles, then go to IDLE.
- SHIFT rules:
  - On each SCK rising edge, shift `ADC_SDO` into a 12-bit register.
  - On each SCK falling edge, advance `ADC_SDI` to the next config bit.
  - After bit 0 of the config word, `ADC_SDI`=0 for the remaining 6 periods.
- Pipelining: the config sent in frame k selects the channel converted in frame k+1. cur_ch latches next_ch at the start of SHIFT. In STORE, the shifted result is written to entry prev_ch, then prev_ch←cur_ch.
- Priming: the first frame after reset is discarded. No write and no `sample_valid` occur in it; STORE only sets primed=1.
- Writes: in STORE with primed=1, write `ch_data[prev_ch]`, pulse `sample_valid`, and set `sample_ch`=prev_ch.
- Channel advance: next_ch increments in STORE and wraps from NUM_CH-1 to 0.
- Width: the sample is exactly 12 bits; no sign extension.
- Enable: deasserting `en` mid-frame does not abort the frame; the FSM parks in IDLE after GAP. Re-enabling does not re-prime.
- Reset mid-frame: all outputs return to reset values immediately. Bank contents are cleared to 0. The next frame is primed again.

## Timing
- One SCK period is 2·SCK_HALF clk cycles.
- Rising edge of `ADC_SCK` and the SDO sample occur in the same clk edge.
- Frame length is 2 + CONV_CYCLES + 24·SCK_HALF + 1 + GAP_CYCLES + 1 clk cycles. This is 136 cycles at defaults.
- Latency from the CONVST rising edge of frame k+1 to `sample_valid` for that data: 2 + CONV_CYCLES + 24·SCK_HALF + 1 cycles, measured in frame k+2's STORE? No — the data converted in frame k+1 is stored in frame k+1's own STORE, with prev_ch labelling it.
- `ch_data` updates and `sample_valid` assert in the same cycle. `ch_data` is stable at all other times.

## Structure
- Package `adc_pkg`:
  - ADC_BITS=12, CFG_BITS=6.
  - Config bit positions and the function `cfg_word(ch)`.
  - FSM state enum {IDLE, CONV, WAIT, SHIFT, STORE, GAP}.
- Sub-module `adc_sck_tick`: SCK_HALF down-counter producing `rise`/`fall` strobes and the SCK level. It is enabled only in SHIFT.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0; release with `en`=0 → no CONVST edge for 1000 cycles.
- Priming: ADC model returns 12'hABC in frame 0 → no `sample_valid`; SDI for frame 0 is 6'b100010 (ch0).
- Pipeline: model returns 12'h100+c for channel c, where c is the channel configured in the previous frame → `ch_data` entry c equals 12'h100+c; `sample_ch` sequence is 0,1,…,7,0.
- Wrap: NUM_CH=3 → SDI configs cycle ch0,ch1,ch2,ch0; entries 3..7 stay 0.
- Reset mid-SHIFT after 5 SCK rises → outputs 0 within the same cycle; the next frame is discarded as priming.
- `en` dropped during WAIT → the frame completes with one `sample_valid`, then no CONVST until `en`=1.
